// File: rtl/mvm_stream_accel.sv
// Purpose : N x N matrix-vector multiply y = A*x over byte-stream valid/ready ports,
//           keeping A across jobs until reset so later jobs may stream only x.
// Latency : last x beat at edge t -> first out_valid in cycle t+N*N+1 (one MAC per cycle).
// Backpr. : in_ready only in LOAD_A/LOAD_X; DRAIN holds out_data/out_last until out_ready.
// Ports   : clk_i/rst_i (sync, active-high); start_i/reload_a_i job command (IDLE only);
//           in_valid_i/in_data_i/in_ready_o operand stream; out_valid_o/out_data_o/
//           out_last_o/out_ready_i result stream; busy_o (not IDLE); done_o (end pulse).
module mvm_stream_accel #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      reload_a_i,
    input  logic                      in_valid_i,
    input  logic [DW-1:0]             in_data_i,
    output logic                      in_ready_o,
    output logic                      out_valid_o,
    output logic [2*DW+$clog2(N)-1:0] out_data_o,
    output logic                      out_last_o,
    input  logic                      out_ready_i,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int OW = 2*DW + $clog2(N);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_X,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] r_q, r_d;       // row index: A load, MAC row, drain index
    logic [CW-1:0] c_q, c_d;       // column index: A load, x load, MAC column
    logic          a_valid_q, a_valid_d;
    logic          done_q, done_d;
    logic [OW-1:0] acc_q, acc_d;

    logic [DW-1:0] a_q [N][N];
    logic [DW-1:0] x_q [N];
    logic [OW-1:0] y_q [N];

    logic [OW-1:0] prod;
    logic [OW-1:0] mac_sum;

    // Extending to OW before multiplying keeps the low OW product bits exact
    // for both two's-complement and unsigned operands.
    function automatic logic [OW-1:0] ext(input logic [DW-1:0] v);
        if (SIGNED) begin
            return {{(OW-DW){v[DW-1]}}, v};
        end
        return {{(OW-DW){1'b0}}, v};
    endfunction

    always_comb begin
        prod    = ext(a_q[r_q][c_q]) * ext(x_q[c_q]);
        mac_sum = ((c_q == '0) ? '0 : acc_q) + prod;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            a_valid_q <= 1'b0;
            done_q    <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            a_valid_q <= a_valid_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
        end
    end

    // Operand/result storage needs no reset: it is only read after being written.
    always_ff @(posedge clk_i) begin
        if (state_q == S_LOAD_A && in_valid_i) begin
            a_q[r_q][c_q] <= in_data_i;
        end
        if (state_q == S_LOAD_X && in_valid_i) begin
            x_q[c_q] <= in_data_i;
        end
        if (state_q == S_COMPUTE && c_q == LAST) begin
            y_q[r_q] <= mac_sum;
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        a_valid_d   = a_valid_q;
        done_d      = 1'b0;
        acc_d       = acc_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        out_data_o  = '0;
        busy_o      = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    r_d = '0;
                    c_d = '0;
                    if (reload_a_i || !a_valid_q) begin
                        // A is about to be overwritten, so it stops being trustworthy now.
                        a_valid_d = 1'b0;
                        state_d   = S_LOAD_A;
                    end else begin
                        state_d = S_LOAD_X;
                    end
                end
            end
            S_LOAD_A: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (c_q == LAST) begin
                        c_d = '0;
                        if (r_q == LAST) begin
                            r_d       = '0;
                            a_valid_d = 1'b1;
                            state_d   = S_LOAD_X;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            S_LOAD_X: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (c_q == LAST) begin
                        c_d     = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                acc_d = mac_sum;
                if (c_q == LAST) begin
                    c_d = '0;
                    if (r_q == LAST) begin
                        r_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            S_DRAIN: begin
                out_valid_o = 1'b1;
                out_data_o  = y_q[r_q];
                out_last_o  = (r_q == LAST);
                if (out_ready_i) begin
                    if (r_q == LAST) begin
                        r_d     = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign done_o = done_q;

endmodule

// File: tb/tb_mvm_stream_accel.sv
module tb_mvm_stream_accel;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam bit SGN = 1'b0;
    localparam int OW  = 2*DW + $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          start, reload_a;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          busy, done;

    mvm_stream_accel #(.N(N), .DW(DW), .SIGNED(SGN)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .reload_a_i (reload_a),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .out_valid_o(out_valid),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .out_ready_i(out_ready),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint d;
        bit     l;
    } exp_t;

    exp_t   exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     in_hs_cnt = 0;
    int     bp_mode = 0;
    bit     m_a_valid = 1'b0;
    int     m_a[N*N];

    function automatic void check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endfunction

    // Element value as the arithmetic sees it (signed or unsigned reading of DW bits).
    function automatic longint elem(input int v);
        logic [DW-1:0] b;
        b = v[DW-1:0];
        if (SGN) return longint'($signed(b));
        return longint'(b);
    endfunction

    // Result stream monitor: pops the scoreboard on each handshake, checks that a
    // stalled beat stays put, and that done pulses exactly after the last beat.
    initial begin
        bit            held = 1'b0;
        bit            exp_done = 1'b0;
        bit            exp_done_nxt;
        logic [OW-1:0] held_data = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held     = 1'b0;
                exp_done = 1'b0;
            end else begin
                if (in_valid && in_ready) in_hs_cnt++;
                if (exp_done || done) begin
                    check("done_pulse", done, exp_done);
                    if (exp_done) check("busy_at_done", busy, 0);
                end
                exp_done_nxt = 1'b0;
                if (held) begin
                    check("out_valid_hold", out_valid, 1);
                    check("out_data_stable", out_data, held_data);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.d);
                        check("out_last", out_last, e.l);
                        exp_done_nxt = e.l;
                    end
                end
                held      = out_valid && !out_ready;
                held_data = out_data;
                exp_done  = exp_done_nxt;
            end
        end
    end

    // out_ready pattern: 0 always ready, 1 random, 2 ten stalled cycles then toggling.
    initial begin
        int bp_cnt = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(1));
                default: begin
                    if (!out_valid) begin
                        bp_cnt    = 0;
                        out_ready = 1'b0;
                    end else begin
                        bp_cnt++;
                        out_ready = (bp_cnt > 10) ? bp_cnt[0] : 1'b0;
                    end
                end
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    task automatic run_job(input bit reload, input int a[N*N], input int x[N],
                           input int gap, input bit noise, input bit abort);
        bit     load_a;
        int     beats[$];
        int     n;
        longint s;
        exp_t   e;
        load_a = reload || !m_a_valid;
        if (load_a) begin
            m_a       = a;
            m_a_valid = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int j = 0; j < N; j++) s += elem(m_a[i*N+j]) * elem(x[j]);
            e.d = s & ((64'd1 << OW) - 1);
            e.l = (i == N-1);
            exp_q.push_back(e);
        end
        if (load_a) foreach (a[i]) beats.push_back(a[i]);
        foreach (x[i]) beats.push_back(x[i]);

        start    = 1'b1;
        reload_a = reload;
        @(posedge clk); #1;
        start     = 1'b0;
        reload_a  = 1'b0;
        in_hs_cnt = 0;
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, 1);

        for (int idx = 0; idx < beats.size(); idx++) begin
            if ($urandom_range(99) < gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (noise && idx == (load_a ? N*N : 0) + 1) begin
                in_valid = 1'b0;
                start    = 1'b1;
                reload_a = 1'b1;
                @(posedge clk); #1;
                start    = 1'b0;
                reload_a = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = beats[idx][DW-1:0];
            n = 0;
            while (!in_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("in_ready_after_x", in_ready, 0);

        n = 0;
        while (!out_valid && n < 100) begin
            if (noise && n < 5) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (abort && n == 5) begin
                exp_q.delete();
                rst = 1'b1;
                @(posedge clk); #1;
                check_reset_outputs();
                rst       = 1'b0;
                m_a_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (noise && n < 5) check("in_ready_in_compute", in_ready, 0);
            n++;
        end
        in_valid = 1'b0;
        check("first_valid_latency", n, N*N);

        if (noise) begin
            start    = 1'b1;
            reload_a = 1'b1;
            @(posedge clk); #1;
            start    = 1'b0;
            reload_a = 1'b0;
        end

        n = 0;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) check("done_timeout", 0, 1);
        check("in_beats", in_hs_cnt, (load_a ? N*N : 0) + N);
        check("scoreboard_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        int a[N*N];
        int x[N];
        rst      = 1'b1;
        start    = 1'b0;
        reload_a = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity matrix
        foreach (a[i]) a[i] = (i / N == i % N) ? 1 : 0;
        x = '{3, 5, 7, 9};
        run_job(1'b1, a, x, 0, 1'b0, 1'b0);

        // Full-scale operands: result needs all OW bits
        foreach (a[i]) a[i] = 255;
        x = '{255, 255, 255, 255};
        run_job(1'b1, a, x, 0, 1'b0, 1'b0);

        // Matrix reuse: second job streams only x
        foreach (a[i]) a[i] = $urandom_range(255);
        x = '{1, 1, 1, 1};
        run_job(1'b1, a, x, 0, 1'b0, 1'b0);
        x = '{2, 0, 0, 0};
        run_job(1'b0, a, x, 0, 1'b0, 1'b0);

        // Output backpressure
        bp_mode = 2;
        foreach (x[i]) x[i] = $urandom_range(255);
        run_job(1'b0, a, x, 0, 1'b0, 1'b0);

        // Reset during COMPUTE, then a reuse request must fall back to loading A
        bp_mode = 1;
        foreach (a[i]) a[i] = $urandom_range(255);
        run_job(1'b1, a, x, 0, 1'b0, 1'b1);
        foreach (a[i]) a[i] = $urandom_range(255);
        foreach (x[i]) x[i] = $urandom_range(255);
        run_job(1'b0, a, x, 30, 1'b0, 1'b0);

        // Ignored start/in_valid outside their states
        bp_mode = 0;
        foreach (x[i]) x[i] = $urandom_range(255);
        run_job(1'b0, a, x, 0, 1'b1, 1'b0);

        // Random mix
        for (int k = 0; k < 6; k++) begin
            bp_mode = $urandom_range(2);
            foreach (a[i]) a[i] = $urandom_range(255);
            foreach (x[i]) x[i] = $urandom_range(255);
            run_job(1'($urandom_range(1)), a, x, $urandom_range(40), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mvm_stream_accel.md
# mvm_stream_accel

Parametrised matrix-vector multiply engine: computes y = A·x for an N×N matrix A and an N-element vector x. Operands are loaded over a valid/ready byte-stream port, and results are returned over a second valid/ready port. It generalises the fixed 2-bit-index, single-byte MVM accelerator in four ways: configurable dimension, configurable element width, a signed/unsigned mode, and matrix retention across jobs. It sits between the CPU-facing pin mux and the top-level wrapper.

## Interface
- N, 4: matrix dimension, legal range 2..8.
- DW, 8: element width of A and x, in bits.
- SIGNED, 0: 1 = two's-complement operands and results; 0 = unsigned.
- OW, 2*DW+$clog2(N): output width. This is derived and must not be overridden.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle job request. Sampled only in IDLE.
- reload_a  in  1  sampled with start. 1 = load a new A; 0 = reuse the stored A.
- in_valid  in  1  operand beat valid.
- in_data  in  DW  operand beat.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- out_valid  out  1  result beat valid.
- out_data  out  OW  result y[i].
- out_last  out  1  high with y[N-1].
- out_ready  in  1  result beat consumed when out_valid && out_ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last result is consumed.

## Operation
- States: IDLE, LOAD_A, LOAD_X, COMPUTE, DRAIN.
- IDLE
  - start=1 && (reload_a=1 || a_valid=0) → LOAD_A.
  - start=1 && reload_a=1'b0 && a_valid=1 → LOAD_X.
  - start=0 → stay in IDLE.
- LOAD_A
  - in_ready=1.
  - Beats are stored row-major: A[r][c] with c incrementing fastest.
  - After N*N accepted beats: a_valid is set and the state moves to LOAD_X.
- LOAD_X
  - in_ready=1.
  - Beats are stored as x[0..N-1].
  - After N accepted beats → COMPUTE.
- COMPUTE
  - One MAC per cycle, row-major. acc = (c==0 ? 0 : acc) + A[r][c]*x[c].
  - The product is sign- or zero-extended to OW according to SIGNED.
  - At c==N-1 the sum is written into y[r].
  - After N*N cycles → DRAIN.
- DRAIN
  - Presents y[0..N-1] in order and advances on each handshake.
  - out_last accompanies the beat for index N-1.
  - After that beat is consumed: done pulses and the state returns to IDLE.
- Arithmetic
  - The full-precision sum always fits in OW bits. There is no saturation and no truncation.
- Boundary rules
  - start or reload_a outside IDLE: ignored.
  - in_valid in IDLE, COMPUTE or DRAIN: ignored, with in_ready=0.
  - a_valid persists across jobs and is cleared only by rst.
  - x and y are never reused; every job reloads x.
  - Stalled in_valid (gaps): the load index holds. There is no timeout.
  - out_ready held low: out_valid and out_data hold stable until the beat is consumed.
  - rst in any state: the next state is IDLE and all counters clear. A partially loaded A does not set a_valid. A job interrupted mid-LOAD_A, or any later job, does not preserve a previously valid A; a_valid=0.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, a_valid=0.
- start in IDLE at edge k: busy=1 and in_ready=1 from cycle k+1.
- Beats are accepted at one per cycle maximum, with no bubbles required.
- Last x beat accepted at edge t:
  - COMPUTE runs at cycles t+1..t+N*N.
  - First out_valid at cycle t+N*N+1.
  - in_ready=0 from t+1 onward.
- DRAIN sustains one result per cycle while out_ready=1.
- done is high in the cycle after the out_last handshake. busy=0 in that same cycle. A new start is accepted in that cycle.
- Minimum job length with reload_a=1 and no stalls is 2 (command) + N*N + N (loads) + N*N + N cycles.

## Test plan
- Identity: N=4, DW=8, SIGNED=0. Load A=I and x={3,5,7,9}. Expect y={3,5,7,9}, out_last on the 4th beat, and first out_valid exactly 17 cycles after the last x beat.
- Overflow width: unsigned, all A and x = 255. Expect every y=260100 (18-bit), with no wrap. In a SIGNED=1 build, all elements = -128 gives every y=65536.
- Matrix reuse: job 1 loads A and x={1,1,1,1}. Job 2 uses reload_a=0 and x={2,0,0,0}. Expect in_ready for exactly 4 beats and y=2·column 0 of A.
- Backpressure: hold out_ready=0 for 10 cycles, then toggle it every other cycle. Expect stable out_data, no lost or duplicated beats, and done only after y[3] is consumed.
- Reset mid-job: assert rst during COMPUTE, then start with reload_a=0. Expect a forced LOAD_A (16 in_ready beats) because a_valid was cleared. All outputs must match their reset values in the cycle after rst.
- Ignored inputs: pulse start during LOAD_X and DRAIN, and drive in_valid during COMPUTE. Expect no state change and no extra beats stored; results are unchanged from the golden model.
